// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready handshakes, an
// optional chained accumulator operand, registered result flags and a completion counter.
module logic_unit_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  input  logic             chain,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             flag_zero,
  output logic             flag_ones,
  output logic             flag_par,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [2:0] {
    OP_AND   = 3'b000,
    OP_OR    = 3'b001,
    OP_XOR   = 3'b010,
    OP_NAND  = 3'b011,
    OP_NOR   = 3'b100,
    OP_XNOR  = 3'b101,
    OP_NOTA  = 3'b110,
    OP_PASSB = 3'b111
  } op_e;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  op_e              s1_sel;
  logic             s1_chain;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] result;
  logic             adv2;
  logic             acc1;

  // out_valid is the S2 valid bit; S2 may refill in the same cycle it drains.
  assign adv2     = s1_valid & (~out_valid | out_ready);
  assign in_ready = ~s1_valid | adv2;
  assign acc1     = in_valid & in_ready;

  always_comb begin
    op_a   = s1_chain ? acc : s1_a;
    result = '0;
    case (s1_sel)
      OP_AND:   result = op_a & s1_b;
      OP_OR:    result = op_a | s1_b;
      OP_XOR:   result = op_a ^ s1_b;
      OP_NAND:  result = ~(op_a & s1_b);
      OP_NOR:   result = ~(op_a | s1_b);
      OP_XNOR:  result = ~(op_a ^ s1_b);
      OP_NOTA:  result = ~op_a;
      OP_PASSB: result = s1_b;
      default:  result = s1_b;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sel   <= OP_AND;
      s1_chain <= 1'b0;
    end else if (acc1) begin
      s1_valid <= 1'b1;
      s1_a     <= a;
      s1_b     <= b;
      s1_sel   <= op_e'(sel);
      s1_chain <= chain;
    end else if (adv2) begin
      s1_valid <= 1'b0;
    end
  end

  // The accumulator follows program order: it tracks every result entering S2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
      flag_zero <= 1'b0;
      flag_ones <= 1'b0;
      flag_par  <= 1'b0;
      acc       <= '0;
    end else if (adv2) begin
      out_valid <= 1'b1;
      out       <= result;
      flag_zero <= (result == '0);
      flag_ones <= (result == '1);
      flag_par  <= ^result;
      acc       <= result;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= '0;
    end else if (out_valid && out_ready) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed, table-driven bench for logic_unit_pipe: streaming, chaining,
// backpressure, mid-operation reset, counter wrap and an 8-bit instance.
module tb_logic_unit_pipe;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  sel;
    logic        chain;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  sel;
  logic        chain;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        flag_zero;
  logic        flag_ones;
  logic        flag_par;
  logic [15:0] op_count;

  logic        in_ready_c4;
  logic        out_valid_c4;
  logic [31:0] out_c4;
  logic        flag_zero_c4;
  logic        flag_ones_c4;
  logic        flag_par_c4;
  logic [3:0]  op_count_c4;

  logic        in_valid8;
  logic        in_ready8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic [2:0]  sel8;
  logic        out_valid8;
  logic [7:0]  out8;
  logic        flag_zero8;
  logic        flag_ones8;
  logic        flag_par8;
  logic [15:0] op_count8;

  int   checks = 0;
  int   errors = 0;
  int   exp_count = 0;
  int   first_cyc;
  vec_t seq [32];

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel), .chain(chain),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .flag_zero(flag_zero), .flag_ones(flag_ones), .flag_par(flag_par),
    .op_count(op_count)
  );

  // Narrow-counter twin driven by the same stimulus, used to observe wrap.
  logic_unit_pipe #(.WIDTH(32), .CNT_W(4)) dut_c4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c4),
    .a(a), .b(b), .sel(sel), .chain(chain),
    .out_valid(out_valid_c4), .out_ready(out_ready), .out(out_c4),
    .flag_zero(flag_zero_c4), .flag_ones(flag_ones_c4), .flag_par(flag_par_c4),
    .op_count(op_count_c4)
  );

  logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .sel(sel8), .chain(1'b0),
    .out_valid(out_valid8), .out_ready(1'b1), .out(out8),
    .flag_zero(flag_zero8), .flag_ones(flag_ones8), .flag_par(flag_par8),
    .op_count(op_count8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] exp);
    check({name, "_out"},  64'(out), 64'(exp));
    check({name, "_zero"}, 64'(flag_zero), 64'(exp == 32'h0));
    check({name, "_ones"}, 64'(flag_ones), 64'(exp == 32'hFFFF_FFFF));
    check({name, "_par"},  64'(flag_par), 64'(^exp));
  endtask

  // Drives seq[0..n_ops-1] honouring in_ready and checks every delivered result in order.
  task automatic applyStimulus(input string tag, input int n_ops, input int stall_from,
                               input int stall_len, output int first_out);
    int idx = 0;
    int got = 0;
    int cyc = 0;
    bit acc_now;
    bit stalled;
    first_out = -1;
    while ((got < n_ops) && (cyc < 200)) begin
      stalled   = (cyc >= stall_from) && (cyc < stall_from + stall_len);
      out_ready = !stalled;
      if (idx < n_ops) begin
        in_valid = 1'b1;
        a        = seq[idx].a;
        b        = seq[idx].b;
        sel      = seq[idx].sel;
        chain    = seq[idx].chain;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      acc_now = in_valid && in_ready;
      if (stalled) begin
        check($sformatf("%s_stall_in_ready_c%0d", tag, cyc), 64'(in_ready), 64'(0));
        check($sformatf("%s_stall_valid_c%0d", tag, cyc), 64'(out_valid), 64'(1));
        check($sformatf("%s_stall_hold_c%0d", tag, cyc), 64'(out), 64'(seq[got].exp));
      end
      if (out_valid && out_ready) begin
        if (first_out < 0) first_out = cyc;
        checkOutput($sformatf("%s_r%0d", tag, got), seq[got].exp);
        check($sformatf("%s_cnt_r%0d", tag, got), 64'(op_count), 64'(exp_count % 65536));
        check($sformatf("%s_cnt4_r%0d", tag, got), 64'(op_count_c4), 64'(exp_count % 16));
        got++;
        exp_count++;
      end
      @(posedge clk);
      #1;
      if (acc_now) idx++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (got < n_ops)
      check($sformatf("%s_timeout_results", tag), 64'(got), 64'(n_ops));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; sel = '0; chain = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; sel8 = '0;
    #12;
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_out",       64'(out), 64'(0));
    check("reset_zero",      64'(flag_zero), 64'(0));
    check("reset_count",     64'(op_count), 64'(0));
    check("reset_in_ready",  64'(in_ready), 64'(1));
    @(posedge clk); #1;
    rst = 1'b0;

    // All eight operations streamed back-to-back.
    seq[0] = '{32'h0000FFFF, 32'hFFFFFFFF, 3'b000, 1'b0, 32'h0000FFFF};
    seq[1] = '{32'h0000FFFF, 32'hFFFFFFFF, 3'b001, 1'b0, 32'hFFFFFFFF};
    seq[2] = '{32'h0000FFFF, 32'hFFFFFFFF, 3'b010, 1'b0, 32'hFFFF0000};
    seq[3] = '{32'h0000FFFF, 32'hFFFFFFFF, 3'b011, 1'b0, 32'hFFFF0000};
    seq[4] = '{32'h0000FFFF, 32'hFFFFFFFF, 3'b100, 1'b0, 32'h00000000};
    seq[5] = '{32'h0000FFFF, 32'hFFFFFFFF, 3'b101, 1'b0, 32'h0000FFFF};
    seq[6] = '{32'h0000FFFF, 32'hFFFFFFFF, 3'b110, 1'b0, 32'hFFFF0000};
    seq[7] = '{32'h0000FFFF, 32'hFFFFFFFF, 3'b111, 1'b0, 32'hFFFFFFFF};
    applyStimulus("ops", 8, 1000, 0, first_cyc);
    check("ops_latency", 64'(first_cyc), 64'(2));
    check("ops_count_end", 64'(op_count), 64'(8));

    seq[0] = '{32'hF0F0F0F0, 32'h00000000, 3'b111, 1'b0, 32'h00000000};
    seq[1] = '{32'h00000000, 32'h0000000F, 3'b001, 1'b1, 32'h0000000F};
    seq[2] = '{32'h00000000, 32'h00000003, 3'b010, 1'b1, 32'h0000000C};
    seq[3] = '{32'h00000000, 32'h00000000, 3'b110, 1'b1, 32'hFFFFFFF3};
    applyStimulus("chain", 4, 1000, 0, first_cyc);

    seq[0] = '{32'h0, 32'h11111111, 3'b111, 1'b0, 32'h11111111};
    seq[1] = '{32'h0, 32'h22222222, 3'b111, 1'b0, 32'h22222222};
    seq[2] = '{32'hAAAA5555, 32'h0F0F0F0F, 3'b000, 1'b0, 32'h0A0A0505};
    seq[3] = '{32'hAAAA5555, 32'h0F0F0F0F, 3'b001, 1'b0, 32'hAFAF5F5F};
    applyStimulus("bp", 4, 2, 3, first_cyc);
    check("bp_count_end", 64'(op_count), 64'(16));

    // Fill both stages with held output, then reset asynchronously mid-cycle.
    out_ready = 1'b0; in_valid = 1'b1; chain = 1'b0; sel = 3'b111; a = '0; b = 32'hAA;
    @(posedge clk); #1;
    b = 32'h55;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mid_pre_valid", 64'(out_valid), 64'(1));
    check("mid_pre_in_ready", 64'(in_ready), 64'(0));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'(0));
    check("mid_rst_out",   64'(out), 64'(0));
    check("mid_rst_zero",  64'(flag_zero), 64'(0));
    check("mid_rst_par",   64'(flag_par), 64'(0));
    check("mid_rst_count", 64'(op_count), 64'(0));
    check("mid_rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    exp_count = 0;
    seq[0] = '{32'hDEADBEEF, 32'h00000001, 3'b001, 1'b1, 32'h00000001};
    applyStimulus("post_rst", 1, 1000, 0, first_cyc);

    for (int i = 0; i < 16; i++)
      seq[i] = '{32'(i), 32'h00FF00FF, 3'b010, 1'b0, 32'(i) ^ 32'h00FF00FF};
    applyStimulus("wrap", 16, 1000, 0, first_cyc);
    check("wrap_count16", 64'(op_count), 64'(17));
    check("wrap_count4",  64'(op_count_c4), 64'(1));

    in_valid8 = 1'b1; a8 = 8'h5A; b8 = 8'h3C; sel8 = 3'b010;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("w8_valid", 64'(out_valid8), 64'(1));
    check("w8_out",   64'(out8), 64'(8'h66));
    check("w8_par",   64'(flag_par8), 64'(0));
    check("w8_zero",  64'(flag_zero8), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
